// File: rtl/tl_source_shrinker.sv
// TileLink A/D source-ID shrinker: maps a wide host source space onto a
// small pool of device source slots. Each first A beat takes the lowest free
// slot and its host source goes into a slot table. D responses are translated
// back through that table, and the slot is released on the last D beat.

// Protocol checker: a D beat must only arrive on a slot that is outstanding.
module tl_source_shrinker_chk #(
    parameter int DeviceSourceWidth = 2
) (
    input logic                              clk_i,
    input logic                              rst_i,
    input logic                              d_fire,
    input logic [DeviceSourceWidth-1:0]      d_source,
    input logic [(2**DeviceSourceWidth)-1:0] busy
);

    d_on_busy_slot_a: assert property (@(posedge clk_i) disable iff (rst_i) d_fire |-> busy[d_source]);

endmodule

module tl_source_shrinker #(
    parameter int HostSourceWidth   = 8,
    parameter int DeviceSourceWidth = 2,
    parameter int SinkWidth         = 1,
    parameter int AddrWidth         = 56,
    parameter int DataWidth         = 64,
    parameter int SizeWidth         = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    // host A
    input  logic                         host_a_valid,
    output logic                         host_a_ready,
    input  logic [2:0]                   host_a_opcode,
    input  logic [2:0]                   host_a_param,
    input  logic [SizeWidth-1:0]         host_a_size,
    input  logic [HostSourceWidth-1:0]   host_a_source,
    input  logic [AddrWidth-1:0]         host_a_address,
    input  logic [DataWidth/8-1:0]       host_a_mask,
    input  logic                         host_a_corrupt,
    input  logic [DataWidth-1:0]         host_a_data,
    // device A
    output logic                         device_a_valid,
    input  logic                         device_a_ready,
    output logic [2:0]                   device_a_opcode,
    output logic [2:0]                   device_a_param,
    output logic [SizeWidth-1:0]         device_a_size,
    output logic [DeviceSourceWidth-1:0] device_a_source,
    output logic [AddrWidth-1:0]         device_a_address,
    output logic [DataWidth/8-1:0]       device_a_mask,
    output logic                         device_a_corrupt,
    output logic [DataWidth-1:0]         device_a_data,
    // device D
    input  logic                         device_d_valid,
    output logic                         device_d_ready,
    input  logic [2:0]                   device_d_opcode,
    input  logic [1:0]                   device_d_param,
    input  logic [SizeWidth-1:0]         device_d_size,
    input  logic [DeviceSourceWidth-1:0] device_d_source,
    input  logic [SinkWidth-1:0]         device_d_sink,
    input  logic                         device_d_denied,
    input  logic                         device_d_corrupt,
    input  logic [DataWidth-1:0]         device_d_data,
    // host D
    output logic                         host_d_valid,
    input  logic                         host_d_ready,
    output logic [2:0]                   host_d_opcode,
    output logic [1:0]                   host_d_param,
    output logic [SizeWidth-1:0]         host_d_size,
    output logic [HostSourceWidth-1:0]   host_d_source,
    output logic [SinkWidth-1:0]         host_d_sink,
    output logic                         host_d_denied,
    output logic                         host_d_corrupt,
    output logic [DataWidth-1:0]         host_d_data,
    // unused B/C/E channels tied off
    output logic                         host_b_valid,
    output logic                         device_b_ready,
    output logic                         device_c_valid,
    output logic                         host_c_ready,
    output logic                         device_e_valid,
    output logic                         host_e_ready
);

    localparam int N        = 2 ** DeviceSourceWidth;
    localparam int Bb       = DataWidth / 8;
    localparam int BbShift  = $clog2(Bb);
    localparam int CntWidth = 2 ** SizeWidth;
    localparam int CntW1    = CntWidth + 1;

    localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntW1-1:0]    BbVal   = CntW1'(Bb);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpAckData    = 3'd1;

    // Beats in a message: one unless it carries data wider than a single beat.
    function automatic logic [CntWidth-1:0] beats_f(input logic [SizeWidth-1:0] size,
                                                    input logic has_data);
        logic [CntW1-1:0] bytes_v;
        bytes_v = {{CntWidth{1'b0}}, 1'b1} << size;
        if (!has_data || (bytes_v <= BbVal)) begin
            beats_f = CntOne;
        end else begin
            beats_f = CntWidth'(bytes_v >> BbShift);
        end
    endfunction

    logic [N-1:0]                 busy_r;
    logic [HostSourceWidth-1:0]   tbl_r [N];
    logic [CntWidth-1:0]          a_cnt_r;
    logic [DeviceSourceWidth-1:0] a_slot_r;
    logic                         a_lock_r;
    logic [CntWidth-1:0]          d_cnt_r;

    logic [DeviceSourceWidth-1:0] cand_s;
    logic                         found_s;
    logic                         a_first_s;
    logic [DeviceSourceWidth-1:0] a_slot_s;
    logic                         a_ok_s;
    logic                         a_fire_s;
    logic [CntWidth-1:0]          a_beats_s;
    logic                         d_fire_s;
    logic [CntWidth-1:0]          d_beats_s;
    logic                         d_last_s;
    logic [N-1:0]                 busy_nxt_s;

    // Lowest-index free slot, scanned from the registered busy vector only.
    always_comb begin
        cand_s  = {DeviceSourceWidth{1'b0}};
        found_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            cand_s  = busy_r[i] ? cand_s : DeviceSourceWidth'(i);
            found_s = found_s | ~busy_r[i];
        end
    end

    // A-side slot selection: a locked offer or a later burst beat keeps its slot.
    assign a_first_s = (a_cnt_r == CntZero);
    assign a_slot_s  = (a_first_s && !a_lock_r) ? cand_s : a_slot_r;
    assign a_ok_s    = !a_first_s || a_lock_r || found_s;
    assign a_beats_s = beats_f(host_a_size, (host_a_opcode == OpPutFull) || (host_a_opcode == OpPutPartial));

    assign device_a_valid   = !rst_i && host_a_valid && a_ok_s;
    assign host_a_ready     = !rst_i && device_a_ready && a_ok_s;
    assign a_fire_s         = host_a_valid && host_a_ready;
    assign device_a_opcode  = host_a_opcode;
    assign device_a_param   = host_a_param;
    assign device_a_size    = host_a_size;
    assign device_a_source  = a_slot_s;
    assign device_a_address = host_a_address;
    assign device_a_mask    = host_a_mask;
    assign device_a_corrupt = host_a_corrupt;
    assign device_a_data    = host_a_data;

    // D-side translation and last-beat detection.
    assign d_beats_s      = beats_f(device_d_size, device_d_opcode == OpAckData);
    assign host_d_valid   = !rst_i && device_d_valid;
    assign device_d_ready = !rst_i && host_d_ready;
    assign d_fire_s       = device_d_valid && device_d_ready;
    assign d_last_s       = (d_cnt_r == CntZero) ? (d_beats_s == CntOne) : (d_cnt_r == CntOne);
    assign host_d_opcode  = device_d_opcode;
    assign host_d_param   = device_d_param;
    assign host_d_size    = device_d_size;
    assign host_d_source  = tbl_r[device_d_source];
    assign host_d_sink    = device_d_sink;
    assign host_d_denied  = device_d_denied;
    assign host_d_corrupt = device_d_corrupt;
    assign host_d_data    = device_d_data;

    assign host_b_valid   = 1'b0;
    assign device_b_ready = 1'b1;
    assign device_c_valid = 1'b0;
    assign host_c_ready   = 1'b1;
    assign device_e_valid = 1'b0;
    assign host_e_ready   = 1'b1;

    // Next busy vector: release on last D beat, claim on first A beat.
    always_comb begin
        busy_nxt_s = busy_r;
        if (d_fire_s && d_last_s) begin
            busy_nxt_s[device_d_source] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (a_fire_s && a_first_s) begin
            busy_nxt_s[a_slot_s] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Slot state, A burst tracking/offer lock and D beat counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_r   <= {N{1'b0}};
            a_cnt_r  <= CntZero;
            a_slot_r <= {DeviceSourceWidth{1'b0}};
            a_lock_r <= 1'b0;
            d_cnt_r  <= CntZero;
        end else begin
            busy_r <= busy_nxt_s;
            if (a_fire_s) begin
                if (a_first_s) begin
                    if (a_beats_s > CntOne) begin
                        a_cnt_r  <= a_beats_s - CntOne;
                        a_lock_r <= 1'b1;
                        a_slot_r <= a_slot_s;
                    end else begin
                        a_lock_r <= 1'b0;
                    end
                end else begin
                    a_cnt_r <= a_cnt_r - CntOne;
                    if (a_cnt_r == CntOne) begin
                        a_lock_r <= 1'b0;
                    end
                end
            end else if (host_a_valid && a_first_s && a_ok_s && !device_a_ready) begin
                a_lock_r <= 1'b1;
                a_slot_r <= a_slot_s;
            end
            if (d_fire_s) begin
                d_cnt_r <= (d_cnt_r == CntZero) ? (d_beats_s - CntOne) : (d_cnt_r - CntOne);
            end
        end
    end

    // Host source table; written when a slot is claimed, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (a_fire_s && a_first_s) begin
            tbl_r[a_slot_s] <= host_a_source;
        end
    end

    tl_source_shrinker_chk #(
        .DeviceSourceWidth(DeviceSourceWidth)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_fire  (d_fire_s),
        .d_source(device_d_source),
        .busy    (busy_r)
    );

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Scoreboard bench for tl_source_shrinker: directed A/D traffic, expected
// device-side A beats and host-side D beats queued at issue time and popped
// by a monitor on every handshake.
module tb_tl_source_shrinker;

    localparam int HSW = 8;
    localparam int DSW = 2;
    localparam int SW  = 3;
    localparam int AW  = 56;
    localparam int DW  = 64;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic           host_a_valid, host_a_ready;
    logic [2:0]     host_a_opcode, host_a_param;
    logic [SW-1:0]  host_a_size;
    logic [HSW-1:0] host_a_source;
    logic [AW-1:0]  host_a_address;
    logic [DW/8-1:0] host_a_mask;
    logic           host_a_corrupt;
    logic [DW-1:0]  host_a_data;
    logic           device_a_valid, device_a_ready;
    logic [2:0]     device_a_opcode, device_a_param;
    logic [SW-1:0]  device_a_size;
    logic [DSW-1:0] device_a_source;
    logic [AW-1:0]  device_a_address;
    logic [DW/8-1:0] device_a_mask;
    logic           device_a_corrupt;
    logic [DW-1:0]  device_a_data;
    logic           device_d_valid, device_d_ready;
    logic [2:0]     device_d_opcode;
    logic [1:0]     device_d_param;
    logic [SW-1:0]  device_d_size;
    logic [DSW-1:0] device_d_source;
    logic [0:0]     device_d_sink;
    logic           device_d_denied, device_d_corrupt;
    logic [DW-1:0]  device_d_data;
    logic           host_d_valid, host_d_ready;
    logic [2:0]     host_d_opcode;
    logic [1:0]     host_d_param;
    logic [SW-1:0]  host_d_size;
    logic [HSW-1:0] host_d_source;
    logic [0:0]     host_d_sink;
    logic           host_d_denied, host_d_corrupt;
    logic [DW-1:0]  host_d_data;
    logic host_b_valid, device_b_ready, device_c_valid, host_c_ready, device_e_valid, host_e_ready;

    tl_source_shrinker dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
        .host_a_opcode(host_a_opcode), .host_a_param(host_a_param), .host_a_size(host_a_size),
        .host_a_source(host_a_source), .host_a_address(host_a_address), .host_a_mask(host_a_mask),
        .host_a_corrupt(host_a_corrupt), .host_a_data(host_a_data),
        .device_a_valid(device_a_valid), .device_a_ready(device_a_ready),
        .device_a_opcode(device_a_opcode), .device_a_param(device_a_param), .device_a_size(device_a_size),
        .device_a_source(device_a_source), .device_a_address(device_a_address), .device_a_mask(device_a_mask),
        .device_a_corrupt(device_a_corrupt), .device_a_data(device_a_data),
        .device_d_valid(device_d_valid), .device_d_ready(device_d_ready),
        .device_d_opcode(device_d_opcode), .device_d_param(device_d_param), .device_d_size(device_d_size),
        .device_d_source(device_d_source), .device_d_sink(device_d_sink), .device_d_denied(device_d_denied),
        .device_d_corrupt(device_d_corrupt), .device_d_data(device_d_data),
        .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
        .host_d_opcode(host_d_opcode), .host_d_param(host_d_param), .host_d_size(host_d_size),
        .host_d_source(host_d_source), .host_d_sink(host_d_sink), .host_d_denied(host_d_denied),
        .host_d_corrupt(host_d_corrupt), .host_d_data(host_d_data),
        .host_b_valid(host_b_valid), .device_b_ready(device_b_ready), .device_c_valid(device_c_valid),
        .host_c_ready(host_c_ready), .device_e_valid(device_e_valid), .host_e_ready(host_e_ready)
    );

    typedef struct packed {
        logic [DSW-1:0] src;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } exp_a_t;

    typedef struct packed {
        logic [HSW-1:0] src;
        logic [DW-1:0]  data;
    } exp_d_t;

    exp_a_t exp_a_q[$];
    exp_d_t exp_d_q[$];
    exp_a_t mon_a;
    exp_d_t mon_d;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [DSW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_a_t e;
        e.src = s; e.addr = a; e.data = d;
        exp_a_q.push_back(e);
    endtask

    task automatic push_d(input logic [HSW-1:0] s, input logic [DW-1:0] d);
        exp_d_t e;
        e.src = s; e.data = d;
        exp_d_q.push_back(e);
    endtask

    // Monitor: every handshake on device A or host D is scored against the queues.
    always @(negedge clk_i) begin
        if (device_a_valid && device_a_ready) begin
            if (exp_a_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected actual_src=%0d required=none", device_a_source);
            end else begin
                mon_a = exp_a_q.pop_front();
                chk("a_src",  64'(device_a_source),  64'(mon_a.src));
                chk("a_addr", 64'(device_a_address), 64'(mon_a.addr));
                chk("a_data", device_a_data, mon_a.data);
            end
        end
        if (host_d_valid && host_d_ready) begin
            if (exp_d_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL d_unexpected actual_src=0x%0h required=none", host_d_source);
            end else begin
                mon_d = exp_d_q.pop_front();
                chk("d_src",  64'(host_d_source), 64'(mon_d.src));
                chk("d_data", host_d_data, mon_d.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic a_offer(input logic [2:0] op, input logic [SW-1:0] sz, input logic [HSW-1:0] src,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        host_a_opcode = op; host_a_size = sz; host_a_source = src;
        host_a_address = addr; host_a_data = data; host_a_valid = 1'b1;
    endtask

    // Hold the offered A beat until it is accepted; wait cycles are checked.
    task automatic a_hold(input string name, input int exp_wait);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!host_a_ready && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        chk(name, 64'(n), 64'(exp_wait));
        tick();
        host_a_valid = 1'b0;
    endtask

    task automatic a_get(input logic [HSW-1:0] src, input logic [DSW-1:0] dsrc, input logic [AW-1:0] addr);
        push_a(dsrc, addr, 64'd0);
        a_offer(3'd4, 3'd3, src, addr, 64'd0);
        a_hold("get_wait", 0);
    endtask

    task automatic d_set(input logic [DSW-1:0] dsrc, input logic [2:0] op, input logic [SW-1:0] sz,
                         input logic [DW-1:0] data);
        device_d_source = dsrc; device_d_opcode = op; device_d_size = sz;
        device_d_data = data; device_d_valid = 1'b1;
    endtask

    task automatic d_beat(input logic [DSW-1:0] dsrc, input logic [2:0] op, input logic [SW-1:0] sz,
                          input logic [DW-1:0] data, input logic [HSW-1:0] exp_src);
        push_d(exp_src, data);
        d_set(dsrc, op, sz, data);
        @(negedge clk_i);
        chk("d_ready", 64'(device_d_ready), 64'd1);
        tick();
        device_d_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        host_a_valid = 1'b1; host_a_opcode = 3'd4; host_a_param = 3'd0; host_a_size = 3'd3;
        host_a_source = 8'h00; host_a_address = 56'd0; host_a_mask = 8'hFF; host_a_corrupt = 1'b0;
        host_a_data = 64'd0; device_a_ready = 1'b1;
        device_d_valid = 1'b1; device_d_opcode = 3'd0; device_d_param = 2'd0; device_d_size = 3'd3;
        device_d_source = 2'd0; device_d_sink = 1'b0; device_d_denied = 1'b0; device_d_corrupt = 1'b0;
        device_d_data = 64'd0; host_d_ready = 1'b1;

        // Reset forces handshakes low even with traffic offered.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_host_a_ready",   64'(host_a_ready),   64'd0);
        chk("rst_device_a_valid", 64'(device_a_valid), 64'd0);
        chk("rst_device_d_ready", 64'(device_d_ready), 64'd0);
        chk("rst_host_d_valid",   64'(host_d_valid),   64'd0);
        chk("tie_b_valid",        64'(host_b_valid),   64'd0);
        chk("tie_e_ready",        64'(host_e_ready),   64'd1);
        tick();
        rst_i = 1'b0; host_a_valid = 1'b0; device_d_valid = 1'b0;

        // Single Get and its AccessAckData.
        a_get(8'hA5, 2'd0, 56'h1000);
        d_beat(2'd0, 3'd1, 3'd3, 64'hDEAD_BEEF_0123_4567, 8'hA5);

        // Fill all four slots, then the fifth stalls until slot 2 frees.
        for (int i = 0; i < 4; i++) begin
            a_get(8'(16 + i), 2'(i), 56'(32'h2000 + i * 8));
        end
        a_offer(3'd4, 3'd3, 8'h14, 56'h3000, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("full_ready", 64'(host_a_ready),   64'd0);
            chk("full_valid", 64'(device_a_valid), 64'd0);
        end
        tick();
        push_d(8'h12, 64'd0);
        d_set(2'd2, 3'd0, 3'd3, 64'd0);
        @(negedge clk_i);
        chk("full_same_cycle_ready", 64'(host_a_ready), 64'd0);
        tick();
        device_d_valid = 1'b0;
        push_a(2'd2, 56'h3000, 64'd0);
        a_hold("full_release", 0);

        // Offer lock: stalled offer keeps slot 1 even after slot 0 frees.
        d_beat(2'd1, 3'd0, 3'd3, 64'd0, 8'h11);
        device_a_ready = 1'b0;
        a_offer(3'd4, 3'd3, 8'h20, 56'h4000, 64'd0);
        @(negedge clk_i);
        chk("lock_valid", 64'(device_a_valid),  64'd1);
        chk("lock_src",   64'(device_a_source), 64'd1);
        tick();
        push_d(8'h10, 64'd0);
        d_set(2'd0, 3'd0, 3'd3, 64'd0);
        @(negedge clk_i);
        chk("lock_src_hold1", 64'(device_a_source), 64'd1);
        tick();
        device_d_valid = 1'b0;
        @(negedge clk_i);
        chk("lock_src_hold2", 64'(device_a_source), 64'd1);
        tick();
        device_a_ready = 1'b1;
        push_a(2'd1, 56'h4000, 64'd0);
        a_hold("lock_release", 0);

        // 4-beat PutFullData with toggling ready; slot 0 frees mid-burst.
        a_get(8'h30, 2'd0, 56'h5000);
        d_beat(2'd2, 3'd0, 3'd3, 64'd0, 8'h14);
        for (int k = 0; k < 4; k++) push_a(2'd2, 56'h6000, 64'(k));
        push_d(8'h30, 64'd0);
        device_d_source = 2'd0; device_d_opcode = 3'd0; device_d_size = 3'd3; device_d_data = 64'd0;
        a_offer(3'd0, 3'd5, 8'h40, 56'h6000, 64'd0);
        for (int c = 0; c < 7; c++) begin
            device_a_ready = (c % 2 == 0);
            host_a_data    = 64'(c / 2);
            device_d_valid = (c == 1);
            tick();
        end
        host_a_valid = 1'b0; device_a_ready = 1'b1; device_d_valid = 1'b0;
        a_get(8'h50, 2'd0, 56'h7000);

        // 8-beat AccessAckData on slot 3: slot stays busy through the last fire.
        push_a(2'd3, 56'h8000, 64'd0);
        a_offer(3'd4, 3'd3, 8'h60, 56'h8000, 64'd0);
        for (int b = 0; b < 8; b++) begin
            push_d(8'h13, 64'(b));
            d_set(2'd3, 3'd1, 3'd6, 64'(b));
            @(negedge clk_i);
            chk("ackdata_busy_hold", 64'(host_a_ready), 64'd0);
            tick();
        end
        device_d_valid = 1'b0;
        a_hold("ackdata_release", 0);

        // Reset in the middle of a 4-beat Put discards all state.
        d_beat(2'd2, 3'd0, 3'd3, 64'd0, 8'h40);
        push_a(2'd2, 56'h9000, 64'd0);
        push_a(2'd2, 56'h9000, 64'd1);
        a_offer(3'd0, 3'd5, 8'h70, 56'h9000, 64'd0);
        a_hold("burst_b0", 0);
        a_offer(3'd0, 3'd5, 8'h70, 56'h9000, 64'd1);
        a_hold("burst_b1", 0);
        a_offer(3'd0, 3'd5, 8'h70, 56'h9000, 64'd2);
        d_set(2'd0, 3'd0, 3'd3, 64'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_host_a_ready",   64'(host_a_ready),   64'd0);
        chk("mid_rst_device_a_valid", 64'(device_a_valid), 64'd0);
        chk("mid_rst_device_d_ready", 64'(device_d_ready), 64'd0);
        chk("mid_rst_host_d_valid",   64'(host_d_valid),   64'd0);
        tick();
        rst_i = 1'b0; host_a_valid = 1'b0; device_d_valid = 1'b0;
        a_get(8'h71, 2'd0, 56'hA000);
        a_get(8'h72, 2'd1, 56'hA008);
        d_beat(2'd0, 3'd1, 3'd3, 64'h0000_0000_0000_1234, 8'h71);

        repeat (3) tick();
        chk("a_queue_empty", 64'(exp_a_q.size()), 64'd0);
        chk("d_queue_empty", 64'(exp_d_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
